// File: rtl/sprite_pkg.sv
// ----------------------------------------------------------------------------
// sprite_pkg
// Shared constants, FSM state type and the ROM address helper for the sprite
// attack animation sequencer and its address pipeline.
//   SPR_W/SPR_H   : sprite frame size in pixels
//   FRAME_WORDS   : ROM words per animation frame (SPR_W*SPR_H)
//   NUM_FRAMES    : frames in the attack animation
//   HOLD_TICKS    : VGA frames each animation frame is shown
//   COOL_TICKS    : VGA frames of cooldown after the animation
//   TRANSPARENT   : palette index that is never drawn
// ----------------------------------------------------------------------------
package sprite_pkg;

   localparam int SPR_W       = 40;
   localparam int SPR_H       = 60;
   localparam int FRAME_WORDS = 2400;
   localparam int NUM_FRAMES  = 4;
   localparam int HOLD_TICKS  = 6;
   localparam int COOL_TICKS  = 8;
   localparam logic [4:0] TRANSPARENT = 5'h00;

   localparam int ADDR_W  = 19;
   localparam int COORD_W = 10;
   localparam int PIX_W   = 5;
   localparam int FRAME_W = 2;
   localparam int CNT_W   = 3;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACTIVE   = 2'd1,
      COOLDOWN = 2'd2
   } state_t;

   // Linear ROM address of one sprite texel; every term is widened to the
   // full address width before multiplying so nothing is truncated.
   function automatic logic [ADDR_W-1:0] sprite_addr(
      input logic [FRAME_W-1:0] frame,
      input logic [COORD_W-1:0] dy,
      input logic [COORD_W-1:0] col
   );
      return ADDR_W'(frame) * ADDR_W'(FRAME_WORDS)
           + ADDR_W'(dy)    * ADDR_W'(SPR_W)
           + ADDR_W'(col);
   endfunction

endpackage

// File: rtl/sprite_attack_seq_if.sv
// ----------------------------------------------------------------------------
// sprite_attack_seq_if
// Pixel/ROM bus of the sprite sequencer.
//   DrawX, DrawY      : current VGA pixel coordinate
//   SpriteX, SpriteY  : sprite top-left corner
//   rom_addr          : read address to the external sprite ROM
//   rom_data          : ROM palette index, one cycle after rom_addr
//   pixel_index       : aligned palette index
//   pixel_valid       : sprite covers the pixel and index is not transparent
// Flow control: there is no valid/ready pair on this bus. A new coordinate is
// accepted on every Clk edge and the result for it appears exactly three edges
// later; the pipeline never stalls and never drops a pixel.
// master = pixel source / ROM side, slave = sprite_attack_seq.
// ----------------------------------------------------------------------------
interface sprite_attack_seq_if;
   import sprite_pkg::*;

   logic [COORD_W-1:0] DrawX;
   logic [COORD_W-1:0] DrawY;
   logic [COORD_W-1:0] SpriteX;
   logic [COORD_W-1:0] SpriteY;
   logic [ADDR_W-1:0]  rom_addr;
   logic [PIX_W-1:0]   rom_data;
   logic [PIX_W-1:0]   pixel_index;
   logic               pixel_valid;

   modport master (
      output DrawX, DrawY, SpriteX, SpriteY, rom_data,
      input  rom_addr, pixel_index, pixel_valid
   );

   modport slave (
      input  DrawX, DrawY, SpriteX, SpriteY, rom_data,
      output rom_addr, pixel_index, pixel_valid
   );

endinterface

// File: rtl/sprite_addr_gen.sv
// ----------------------------------------------------------------------------
// sprite_addr_gen
// Stages 0-1 of the sprite pixel pipeline plus the window-flag delay line.
//   Clk, Reset_n       : clock, async active-low reset
//   facing             : 1 = mirror the sprite horizontally
//   anim_frame         : animation frame used for the address (sampled here)
//   DrawX/DrawY        : pixel coordinate
//   SpriteX/SpriteY    : sprite top-left corner
//   rom_addr           : registered ROM address (0 outside the sprite)
//   in_win_d2          : window flag aligned with the ROM's output data
// ----------------------------------------------------------------------------
module sprite_addr_gen
   import sprite_pkg::*;
(
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               facing,
   input  logic [FRAME_W-1:0] anim_frame,
   input  logic [COORD_W-1:0] DrawX,
   input  logic [COORD_W-1:0] DrawY,
   input  logic [COORD_W-1:0] SpriteX,
   input  logic [COORD_W-1:0] SpriteY,
   output logic [ADDR_W-1:0]  rom_addr,
   output logic               in_win_d2
);

   logic [COORD_W-1:0] dx;
   logic [COORD_W-1:0] dy;
   logic [COORD_W-1:0] col;
   logic               in_win;
   logic               in_win_d1;

   // Stage 0. dx/dy wrap when the pixel is left of / above the sprite, so the
   // explicit >= tests are what reject those pixels.
   always_comb begin
      dx     = DrawX - SpriteX;
      dy     = DrawY - SpriteY;
      in_win = (DrawX >= SpriteX) && (dx < COORD_W'(SPR_W)) &&
               (DrawY >= SpriteY) && (dy < COORD_W'(SPR_H));
      col    = facing ? (COORD_W'(SPR_W - 1) - dx) : dx;
   end

   // Stage 1 and the window-flag delay. anim_frame is taken here, so a frame
   // change only affects pixels entering after it.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rom_addr  <= '0;
         in_win_d1 <= 1'b0;
         in_win_d2 <= 1'b0;
      end else begin
         rom_addr  <= in_win ? sprite_addr(anim_frame, dy, col) : '0;
         in_win_d1 <= in_win;
         in_win_d2 <= in_win_d1;
      end
   end

endmodule

// File: rtl/sprite_attack_seq.sv
// ----------------------------------------------------------------------------
// sprite_attack_seq
// Attack animation sequencer for a 40x60 sprite with a 3-cycle pixel pipeline
// that addresses an external sprite ROM (1-cycle registered read).
//   Clk, Reset_n  : clock, async active-low reset
//   frame_tick    : one-cycle pulse per VGA frame
//   attack_req    : starts an attack when the sequencer is idle
//   facing_left   : 1 = mirror sprite; frozen while an attack runs
//   pix           : pixel/ROM bus (coordinates, rom_addr/rom_data, pixel out)
//   busy          : high in ACTIVE and COOLDOWN
//   anim_done     : one-cycle pulse when the last animation frame ends
//   anim_frame    : animation frame currently displayed
//   state_dbg     : current FSM state
// ----------------------------------------------------------------------------
module sprite_attack_seq
   import sprite_pkg::*;
(
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic                frame_tick,
   input  logic                attack_req,
   input  logic                facing_left,
   sprite_attack_seq_if.slave  pix,
   output logic                busy,
   output logic                anim_done,
   output logic [FRAME_W-1:0]  anim_frame,
   output state_t              state_dbg
);

   localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(HOLD_TICKS - 1);
   localparam logic [CNT_W-1:0]   COOL_LAST  = CNT_W'(COOL_TICKS - 1);
   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);

   state_t             state;
   logic [CNT_W-1:0]   hold_cnt;
   logic [CNT_W-1:0]   cool_cnt;
   logic               facing_lat;
   logic               facing_eff;
   logic               in_win_d2;

   // Idle follows the live input; otherwise the value captured at attack start.
   assign facing_eff = (state == IDLE) ? facing_left : facing_lat;
   assign state_dbg  = state;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= IDLE;
         hold_cnt   <= '0;
         cool_cnt   <= '0;
         anim_frame <= '0;
         facing_lat <= 1'b0;
         busy       <= 1'b0;
         anim_done  <= 1'b0;
      end else begin
         anim_done <= 1'b0;
         unique case (state)
            IDLE: begin
               anim_frame <= '0;
               // A tick arriving with the request is deliberately not counted.
               if (attack_req) begin
                  state      <= ACTIVE;
                  hold_cnt   <= '0;
                  facing_lat <= facing_left;
                  busy       <= 1'b1;
               end
            end
            ACTIVE: begin
               if (frame_tick) begin
                  if (hold_cnt == HOLD_LAST) begin
                     hold_cnt <= '0;
                     if (anim_frame == FRAME_LAST) begin
                        state      <= COOLDOWN;
                        anim_frame <= '0;
                        cool_cnt   <= '0;
                        anim_done  <= 1'b1;
                     end else begin
                        anim_frame <= anim_frame + 1'b1;
                     end
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
            end
            COOLDOWN: begin
               if (frame_tick) begin
                  if (cool_cnt == COOL_LAST) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     cool_cnt <= cool_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   sprite_addr_gen u_addr_gen (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .facing     (facing_eff),
      .anim_frame (anim_frame),
      .DrawX      (pix.DrawX),
      .DrawY      (pix.DrawY),
      .SpriteX    (pix.SpriteX),
      .SpriteY    (pix.SpriteY),
      .rom_addr   (pix.rom_addr),
      .in_win_d2  (in_win_d2)
   );

   // Stage 3: register the ROM data together with its window flag.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         pix.pixel_index <= '0;
         pix.pixel_valid <= 1'b0;
      end else begin
         pix.pixel_index <= pix.rom_data;
         pix.pixel_valid <= in_win_d2 && (pix.rom_data != TRANSPARENT);
      end
   end

endmodule

// File: tb/tb_sprite_attack_seq.sv
// ----------------------------------------------------------------------------
// tb_sprite_attack_seq
// Directed bench for sprite_attack_seq with a small registered ROM model.
// ROM model: data = addr[4:0] ^ 5'h0A, or 0 when rom_zero is set.
// ----------------------------------------------------------------------------
module tb_sprite_attack_seq;
   import sprite_pkg::*;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic               frame_tick = 1'b0;
   logic               attack_req = 1'b0;
   logic               facing_left = 1'b0;
   logic               rom_zero = 1'b0;
   logic               busy;
   logic               anim_done;
   logic [FRAME_W-1:0] anim_frame;
   state_t             state_dbg;

   sprite_attack_seq_if pix ();

   sprite_attack_seq dut (
      .Clk         (clk),
      .Reset_n     (rst_n),
      .frame_tick  (frame_tick),
      .attack_req  (attack_req),
      .facing_left (facing_left),
      .pix         (pix),
      .busy        (busy),
      .anim_done   (anim_done),
      .anim_frame  (anim_frame),
      .state_dbg   (state_dbg)
   );

   always @(posedge clk)
      pix.rom_data <= rom_zero ? 5'h00 : (pix.rom_addr[4:0] ^ 5'h0A);

   // scoreboard counters
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_draw(input int x, input int y);
      pix.DrawX = COORD_W'(x);
      pix.DrawY = COORD_W'(y);
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
   endtask

   // apply a coordinate, check the address after 1 edge, the pixel after 3
   task automatic pixel_case(input string tag, input int x, input int y,
                             input int exp_addr, input int exp_valid, input int exp_idx);
      set_draw(x, y);
      step();
      check({tag, "_addr"}, 32'(pix.rom_addr), 32'(exp_addr));
      step();
      step();
      check({tag, "_valid"}, 32'(pix.pixel_valid), 32'(exp_valid));
      if (exp_valid != 0)
         check({tag, "_idx"}, 32'(pix.pixel_index), 32'(exp_idx));
   endtask

   initial begin
      pix.SpriteX = 10'd100;
      pix.SpriteY = 10'd50;
      set_draw(0, 0);

      // reset state
      #2 rst_n = 1'b0;
      repeat (3) step();
      check("rst_addr",  32'(pix.rom_addr), 0);
      check("rst_valid", 32'(pix.pixel_valid), 0);
      check("rst_idx",   32'(pix.pixel_index), 0);
      check("rst_busy",  32'(busy), 0);
      check("rst_done",  32'(anim_done), 0);
      check("rst_frame", 32'(anim_frame), 0);
      check("rst_state", 32'(state_dbg), 32'(IDLE));
      rst_n = 1'b1;
      step();
      check("post_rst_state", 32'(state_dbg), 32'(IDLE));

      // idle drawing, mirror, boundaries, transparency
      pixel_case("idle",     105, 52, 85, 1, 31);
      facing_left = 1'b1;
      pixel_case("mirror",   105, 52, 114, 1, 24);
      facing_left = 1'b0;
      pixel_case("right_in", 139, 52, 119, 1, 29);
      pixel_case("right_out", 140, 52, 0, 0, 0);
      pixel_case("above",    105, 49, 0, 0, 0);
      pixel_case("below",    105, 110, 0, 0, 0);
      pixel_case("left",      99, 52, 0, 0, 0);
      rom_zero = 1'b1;
      pixel_case("transp",   105, 52, 85, 0, 0);
      rom_zero = 1'b0;

      // full attack, facing captured as 0 then the live input flips
      attack_req = 1'b1;
      step();
      attack_req = 1'b0;
      check("atk_busy",  32'(busy), 1);
      check("atk_state", 32'(state_dbg), 32'(ACTIVE));
      check("atk_frame", 32'(anim_frame), 0);
      facing_left = 1'b1;
      set_draw(139, 109);
      step();
      check("freeze_addr", 32'(pix.rom_addr), 2399);
      attack_req = 1'b1;  // must be ignored while busy
      for (int n = 1; n <= 24; n++) begin
         frame_tick = 1'b1;
         step();
         check("tick_done", 32'(anim_done), (n == 24) ? 1 : 0);
         check("tick_frame", 32'(anim_frame), (n < 24) ? 32'(n / 6) : 0);
         // address registered on the tick edge still uses the old frame
         check("tick_addr_old", 32'(pix.rom_addr), 32'(((n - 1) / 6) * 2400 + 2399));
         frame_tick = 1'b0;
         step();
         check("gap_done", 32'(anim_done), 0);
         check("gap_addr", 32'(pix.rom_addr), (n < 24) ? 32'((n / 6) * 2400 + 2399) : 2399);
         check("gap_busy", 32'(busy), 1);
      end
      check("cool_state", 32'(state_dbg), 32'(COOLDOWN));
      for (int c = 1; c <= 8; c++) begin
         if (c == 8) attack_req = 1'b0;
         tick();
         check("cool_busy", 32'(busy), (c < 8) ? 1 : 0);
         check("cool_st", 32'(state_dbg), (c < 8) ? 32'(COOLDOWN) : 32'(IDLE));
         check("cool_done", 32'(anim_done), 0);
      end
      step();
      check("no_restart", 32'(state_dbg), 32'(IDLE));

      // idle: facing follows the live input again
      set_draw(105, 52);
      step();
      check("idle_follow_l", 32'(pix.rom_addr), 114);
      facing_left = 1'b0;
      step();
      check("idle_follow_r", 32'(pix.rom_addr), 85);

      // reset during frame 2
      attack_req = 1'b1;
      step();
      attack_req = 1'b0;
      repeat (15) tick();
      check("f2_frame", 32'(anim_frame), 2);
      check("f2_addr",  32'(pix.rom_addr), 4885);
      check("f2_valid", 32'(pix.pixel_valid), 1);
      rst_n = 1'b0;
      #1;
      check("arst_frame", 32'(anim_frame), 0);
      check("arst_busy",  32'(busy), 0);
      check("arst_done",  32'(anim_done), 0);
      check("arst_addr",  32'(pix.rom_addr), 0);
      check("arst_valid", 32'(pix.pixel_valid), 0);
      step();
      rst_n = 1'b1;
      step();
      check("arst_state", 32'(state_dbg), 32'(IDLE));
      check("arst_done2", 32'(anim_done), 0);

      // request and tick together: the tick is not counted
      attack_req = 1'b1;
      frame_tick = 1'b1;
      step();
      attack_req = 1'b0;
      frame_tick = 1'b0;
      check("same_state", 32'(state_dbg), 32'(ACTIVE));
      repeat (5) tick();
      check("same_frame5", 32'(anim_frame), 0);
      tick();
      check("same_frame6", 32'(anim_frame), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
